fanout_fifo_responder: RTL

Buffered fan-out stage for the asynchronous dataflow fabric. On its input side it acts as a requester: it pulls tokens from an upstream responder (`producer`, or the output side of an operator). On its output side it acts as a responder: it serves several downstream requesters from a FIFO, each at its own pace. An entry is retired only after every branch has taken it. The block sits wherever one producer drives multiple consumers that must not run in lockstep.

---
 rtl/fanout_fifo_responder.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fanout_fifo_responder.sv
// fanout_fifo_responder: buffered one-to-many fan-out stage.
// The input side pulls tokens from an upstream responder one request at a time.
// The output side serves each downstream branch independently from a shared FIFO.
// An entry is retired only once every branch's read pointer has moved past it.

// One downstream branch. It serves a token for each sampled request when its
// pointer has not caught up with the writer. The acknowledge clears itself, so a
// branch moves at most one token every two cycles.
module fanout_fifo_branch #(
  parameter int data_width = 32,
  parameter int pw         = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [pw-1:0]         wp,
  input  logic [data_width-1:0] rdata,
  output logic                  ack,
  output logic [data_width-1:0] dout,
  output logic [pw-1:0]         rp
);
  logic fire;

  assign fire = req && !ack && (rp != wp);

  // Acknowledge, load the token and advance the pointer together; dout holds between acks.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ack  <= 1'b0;
      dout <= '0;
      rp   <= '0;
    end else begin
      ack <= fire;
      if (fire) begin
        dout <= rdata;
        rp   <= rp + 1'b1;
      end
    end
endmodule

module fanout_fifo_responder #(
  parameter int data_width  = 32,
  parameter int depth       = 4,
  parameter int output_size = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  output logic                              req_l,
  input  logic                              ack_l,
  input  logic [data_width-1:0]             din,
  input  logic [output_size-1:0]            req_r,
  output logic [output_size-1:0]            ack_r,
  output logic [data_width*output_size-1:0] dout,
  output logic [$clog2(depth):0]            level,
  output logic [31:0]                       count
);
  localparam int aw = $clog2(depth);
  localparam int pw = aw + 1;

  logic [data_width-1:0]                    mem [depth];
  logic [pw-1:0]                            wp, tp;
  logic [output_size-1:0][pw-1:0]           rp;
  logic [output_size-1:0][data_width-1:0]   rdata;
  logic [output_size-1:0][data_width-1:0]   dout_a;
  logic [output_size-1:0]                   passed;
  logic                                     wr, has_space, retire;

  // Pointers carry a wrap bit, so the plain difference is the occupancy even at full.
  assign level     = wp - tp;
  assign has_space = level < pw'(depth);
  // An ack with no request outstanding is ignored rather than written.
  assign wr        = req_l && ack_l;
  // An entry retires only when every branch has read past it.
  assign retire    = &passed;
  assign dout      = dout_a;

  // Upstream requester: one outstanding request; req_l drops on the accepting edge
  // and cannot rise again while the acknowledge is still visible.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      req_l <= 1'b0;
      wp    <= '0;
    end else if (wr) begin
      req_l <= 1'b0;
      wp    <= wp + 1'b1;
    end else if (!req_l && !ack_l && has_space) begin
      req_l <= 1'b1;
    end

  // Token storage; contents are don't-care after reset so it has none.
  always_ff @(posedge clk)
    if (wr) mem[wp[aw-1:0]] <= din;

  for (genvar k = 0; k < output_size; k++) begin : g_br
    assign rdata[k]  = mem[rp[k][aw-1:0]];
    assign passed[k] = rp[k] != tp;

    fanout_fifo_branch #(
      .data_width(data_width),
      .pw        (pw)
    ) u_br (
      .clk  (clk),
      .rst  (rst),
      .req  (req_r[k]),
      .wp   (wp),
      .rdata(rdata[k]),
      .ack  (ack_r[k]),
      .dout (dout_a[k]),
      .rp   (rp[k])
    );
  end

  // Retire at most one fully-consumed entry per cycle and keep a running total.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tp    <= '0;
      count <= '0;
    end else if (retire) begin
      tp    <= tp + 1'b1;
      count <= count + 32'd1;
    end
endmodule
